// File: rtl/kronos_mem_arbiter_pkg.sv
// Shared types for the kronos memory arbiter: grant owner encoding and bus widths.
package kronos_mem_arbiter_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned MASKW = XLEN / 8;

  // Port that won the SRAM in the previous cycle; decodes directly into the grant pulses.
  typedef enum logic [1:0] {
    ARB_NONE  = 2'd0,
    ARB_INSTR = 2'd1,
    ARB_DATA  = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/kronos_mem_arbiter.sv
// kronos_mem_arbiter: shares one single-port synchronous SRAM between the core's
// instruction and data ports. Data wins by default; defining
// KRONOS_ARB_STARVE_GUARD_EN adds a counter that forces an instruction fetch through
// after MAX_STALL consecutive losses.
module kronos_mem_arbiter
  import kronos_mem_arbiter_pkg::*;
#(
  parameter int unsigned MEMSIZE   = 11,
  parameter int unsigned MAX_STALL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    instr_addr,
  input  logic               instr_req,
  output logic               instr_gnt,
  output logic [XLEN-1:0]    instr_data,
  input  logic [XLEN-1:0]    data_addr,
  input  logic               data_rd_req,
  input  logic               data_wr_req,
  input  logic [XLEN-1:0]    data_wr_data,
  input  logic [MASKW-1:0]   data_wr_mask,
  output logic               data_gnt,
  output logic [XLEN-1:0]    data_rd_data,
  output logic               mem_en,
  output logic               mem_wren,
  output logic [MEMSIZE-1:0] mem_addr,
  output logic [XLEN-1:0]    mem_wdata,
  output logic [MASKW-1:0]   mem_wmask,
  input  logic [XLEN-1:0]    mem_rdata
);

  arb_owner_e owner;
  arb_owner_e winner;
  logic       data_req;
  logic       force_instr;
  logic       unused_inputs;

  assign data_req = data_rd_req | data_wr_req;

`ifdef KRONOS_ARB_STARVE_GUARD_EN
  localparam int unsigned STALLW = $clog2(MAX_STALL + 1);

  logic [STALLW-1:0] stall_cnt;

  assign force_instr = instr_req && (stall_cnt == STALLW'(MAX_STALL));

  // Count consecutive cycles the fetch loses; saturate at the limit, clear on a win or idle fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!instr_req || (winner == ARB_INSTR)) begin
      stall_cnt <= '0;
    end else if (stall_cnt != STALLW'(MAX_STALL)) begin
      stall_cnt <= stall_cnt + STALLW'(1);
    end
  end

  assign unused_inputs = ^{instr_addr, data_addr};
`else
  assign force_instr   = 1'b0;
  assign unused_inputs = ^{instr_addr, data_addr, 32'(MAX_STALL)};
`endif

  // Pick this cycle's winner and drive the SRAM request directly from it.
  always_comb begin
    winner   = ARB_NONE;
    mem_en   = 1'b0;
    mem_wren = 1'b0;
    mem_addr = '0;
    if (force_instr) begin
      winner   = ARB_INSTR;
      mem_en   = 1'b1;
      mem_addr = instr_addr[2 +: MEMSIZE];
    end else if (data_req) begin
      winner   = ARB_DATA;
      mem_en   = 1'b1;
      mem_wren = data_wr_req;
      mem_addr = data_addr[2 +: MEMSIZE];
    end else if (instr_req) begin
      winner   = ARB_INSTR;
      mem_en   = 1'b1;
      mem_addr = instr_addr[2 +: MEMSIZE];
    end
  end

  // Remember the winner so its grant lines up with the SRAM read data one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= ARB_NONE;
      instr_gnt <= 1'b0;
      data_gnt  <= 1'b0;
    end else begin
      owner     <= winner;
      instr_gnt <= (winner == ARB_INSTR);
      data_gnt  <= (winner == ARB_DATA);
    end
  end

  assign mem_wdata    = data_wr_data;
  assign mem_wmask    = data_wr_mask;
  assign instr_data   = mem_rdata;
  assign data_rd_data = mem_rdata;

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Bench for kronos_mem_arbiter: directed scenarios followed by random traffic, checked
// by a reference model that pushes expected grants into a scoreboard queue and a
// monitor that pops one entry per cycle. Honours KRONOS_ARB_STARVE_GUARD_EN.
module tb_kronos_mem_arbiter;
  import kronos_mem_arbiter_pkg::*;

  localparam int unsigned MEMSIZE   = 11;
  localparam int unsigned MAX_STALL = 4;
  localparam int unsigned DEPTH     = 1 << MEMSIZE;
`ifdef KRONOS_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        instr_addr;
  logic               instr_req;
  logic               instr_gnt;
  logic [31:0]        instr_data;
  logic [31:0]        data_addr;
  logic               data_rd_req;
  logic               data_wr_req;
  logic [31:0]        data_wr_data;
  logic [3:0]         data_wr_mask;
  logic               data_gnt;
  logic [31:0]        data_rd_data;
  logic               mem_en;
  logic               mem_wren;
  logic [MEMSIZE-1:0] mem_addr;
  logic [31:0]        mem_wdata;
  logic [3:0]         mem_wmask;
  logic [31:0]        mem_rdata;

  int tests = 0;
  int fails = 0;

  typedef struct {
    arb_owner_e  port;
    logic [31:0] data;
    bit          rd;
  } exp_t;

  exp_t exp_q[$];

  kronos_mem_arbiter #(.MEMSIZE(MEMSIZE), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst(rst),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_gnt(instr_gnt), .instr_data(instr_data),
    .data_addr(data_addr), .data_rd_req(data_rd_req), .data_wr_req(data_wr_req),
    .data_wr_data(data_wr_data), .data_wr_mask(data_wr_mask), .data_gnt(data_gnt),
    .data_rd_data(data_rd_data), .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 0) return 32'h0000_0013;
    return {16'(i) ^ 16'hA5A5, ~16'(i)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    if ($urandom_range(0, 3) != 0) a = a & 32'h0000_007F;
    return a;
  endfunction

  // Behavioural single-port SRAM with byte-masked writes and registered reads.
  logic [31:0] sram [DEPTH];
  initial begin : sram_model
    for (int i = 0; i < DEPTH; i++) sram[i] = init_word(i);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_wren) begin
          for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) sram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          mem_rdata = sram[mem_addr];
        end
      end
    end
  end

  // Reference model: decide the winner from the priority rules, check the SRAM request, queue the grant.
  logic [31:0] mem_ref [DEPTH];
  initial begin : ref_model
    int          stall;
    arb_owner_e  w;
    logic [31:0] a;
    int unsigned idx;
    exp_t        e;
    stall = 0;
    for (int i = 0; i < DEPTH; i++) mem_ref[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (GUARD && instr_req && stall == MAX_STALL) w = ARB_INSTR;
      else if (data_rd_req || data_wr_req)          w = ARB_DATA;
      else if (instr_req)                           w = ARB_INSTR;
      else                                          w = ARB_NONE;
      a   = (w == ARB_INSTR) ? instr_addr : (w == ARB_DATA) ? data_addr : 32'h0;
      idx = (a >> 2) % DEPTH;
      check("mem_en", 32'(mem_en), 32'(w != ARB_NONE));
      check("mem_addr", 32'(mem_addr), idx);
      check("mem_wren", 32'(mem_wren), 32'(w == ARB_DATA && data_wr_req));
      e.port = rst ? ARB_NONE : w;
      e.rd   = (w == ARB_INSTR) || (w == ARB_DATA && !data_wr_req);
      e.data = mem_ref[idx];
      if (w == ARB_DATA && data_wr_req) begin
        check("mem_wdata", mem_wdata, data_wr_data);
        for (int b = 0; b < 4; b++)
          if (data_wr_mask[b]) mem_ref[idx][8*b +: 8] = data_wr_data[8*b +: 8];
      end
      if (rst || !instr_req || w == ARB_INSTR) stall = 0;
      else if (stall < MAX_STALL) stall = stall + 1;
      exp_q.push_back(e);
    end
  end

  // Monitor: one scoreboard entry per cycle, compared against the grant pulses and read data.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() == 0) continue;
      e = exp_q.pop_front();
      check("instr_gnt", 32'(instr_gnt), 32'(e.port == ARB_INSTR));
      check("data_gnt", 32'(data_gnt), 32'(e.port == ARB_DATA));
      if (e.port == ARB_INSTR && instr_gnt) check("instr_data", instr_data, e.data);
      if (e.port == ARB_DATA && data_gnt && e.rd) check("data_rd_data", data_rd_data, e.data);
    end
  end

  // Stimulus: directed scenarios, then random requesters that hold each request until granted.
  initial begin : stimulus
    int          first_instr;
    bit          data_at_first;
    logic [31:0] w_old;
    rst = 1'b1; instr_req = 1'b0; instr_addr = '0;
    data_rd_req = 1'b0; data_wr_req = 1'b0; data_addr = '0;
    data_wr_data = '0; data_wr_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_instr_gnt", 32'(instr_gnt), 32'd0);
    check("reset_data_gnt", 32'(data_gnt), 32'd0);
    rst = 1'b0;

    instr_req = 1'b1; instr_addr = 32'h0;
    step();
    check("fetch_gnt", 32'(instr_gnt), 32'd1);
    check("fetch_data", instr_data, 32'h0000_0013);
    repeat (2) begin
      step();
      check("fetch_stream_gnt", 32'(instr_gnt), 32'd1);
    end
    instr_req = 1'b0;
    step();

    instr_req = 1'b1; instr_addr = 32'h4;
    data_rd_req = 1'b1; data_addr = 32'h100;
    #1;
    check("collide_mem_addr", 32'(mem_addr), 32'h40);
    step();
    check("collide_data_gnt", 32'(data_gnt), 32'd1);
    check("collide_instr_wait", 32'(instr_gnt), 32'd0);
    data_rd_req = 1'b0;
    step();
    check("collide_instr_gnt", 32'(instr_gnt), 32'd1);
    check("collide_instr_data", instr_data, init_word(1));
    instr_req = 1'b0;

    data_wr_req = 1'b1; data_addr = 32'h200;
    data_wr_data = 32'hDEAD_BEEF; data_wr_mask = 4'b0011;
    #1;
    check("store_wren", 32'(mem_wren), 32'd1);
    step();
    check("store_gnt", 32'(data_gnt), 32'd1);
    data_wr_req = 1'b0; data_rd_req = 1'b1;
    step();
    w_old = init_word(32'h80);
    check("load_gnt", 32'(data_gnt), 32'd1);
    check("load_merged", data_rd_data, {w_old[31:16], 16'hBEEF});
    data_rd_req = 1'b0;

    data_rd_req = 1'b1; data_addr = (32'd1 << (MEMSIZE + 2)) + 32'h8;
    #1;
    check("wrap_mem_addr", 32'(mem_addr), 32'd2);
    step();
    check("wrap_data", data_rd_data, init_word(2));
    data_rd_req = 1'b0;

    data_rd_req = 1'b1; data_addr = 32'h10; rst = 1'b1;
    step();
    check("rst_drop_gnt", 32'(data_gnt), 32'd0);
    data_rd_req = 1'b0; rst = 1'b0;
    step();
    check("rst_idle_data_gnt", 32'(data_gnt), 32'd0);
    check("rst_idle_instr_gnt", 32'(instr_gnt), 32'd0);
    data_rd_req = 1'b1;
    step();
    check("rst_reissue_gnt", 32'(data_gnt), 32'd1);
    check("rst_reissue_data", data_rd_data, init_word(4));
    data_rd_req = 1'b0;
    step();

    instr_req = 1'b1; instr_addr = 32'h8;
    data_rd_req = 1'b1; data_addr = 32'h20;
    first_instr = -1; data_at_first = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (instr_gnt && first_instr < 0) begin
        first_instr   = k;
        data_at_first = data_gnt;
      end
    end
    if (GUARD) begin
      check("guard_first_instr", 32'(first_instr), 32'd5);
      check("guard_data_waits", 32'(data_at_first), 32'd0);
    end else begin
      check("strict_no_instr", 32'(first_instr), 32'hFFFF_FFFF);
    end
    instr_req = 1'b0; data_rd_req = 1'b0;
    step();

    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 199) == 0);
      if (!instr_req || instr_gnt) begin
        instr_req  = ($urandom_range(0, 3) != 0);
        instr_addr = rand_addr();
      end
      if (!(data_rd_req || data_wr_req) || data_gnt) begin
        data_rd_req  = ($urandom_range(0, 3) == 0);
        data_wr_req  = ($urandom_range(0, 3) == 0);
        data_addr    = rand_addr();
        data_wr_data = $urandom();
        data_wr_mask = 4'($urandom());
      end
    end
    rst = 1'b0; instr_req = 1'b0; data_rd_req = 1'b0; data_wr_req = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
